// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: frames a serial sample stream onto the parallel inputs of
// the combinational fft8 core, waits a settle window, captures the 16 result
// words and streams them back out as 8 complex beats under valid/ready.
module fft8_frame_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic [255:0] fft_a,
  input  logic [255:0] fft_xr,
  input  logic [255:0] fft_xi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_re,
  output logic [31:0]  out_im,
  output logic [2:0]   out_idx,
  output logic         out_last,
  output logic         frame_err,
  output logic [15:0]  frames_done
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_UNLOAD  = 2'd3
  } state_e;

  // Counter preload: the window covers SETTLE_CYCLES cycles ending on count 0.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic [2:0]  rd_idx_q, rd_idx_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [31:0] samp_q [8];
  logic [31:0] samp_d [8];
  logic [31:0] res_re_q [8];
  logic [31:0] res_re_d [8];
  logic [31:0] res_im_q [8];
  logic [31:0] res_im_d [8];
  logic        frame_err_q, frame_err_d;
  logic [15:0] frames_done_q, frames_done_d;

  // Next-state and datapath updates for the four-phase frame sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    settle_cnt_d  = settle_cnt_q;
    samp_d        = samp_q;
    res_re_d      = res_re_q;
    res_im_d      = res_im_q;
    frame_err_d   = 1'b0;
    frames_done_d = frames_done_q;

    unique case (state_q)
      ST_LOAD: begin
        // in_ready is 1 throughout LOAD, so in_valid alone is the handshake.
        if (in_valid) begin
          samp_d[wr_idx_q] = in_data;
          if (wr_idx_q == 3'd7) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_INIT;
            wr_idx_d     = 3'd0;
          end else if (in_last) begin
            // Early in_last: restart the frame; stale lanes get overwritten.
            frame_err_d = 1'b1;
            wr_idx_d    = 3'd0;
          end else begin
            wr_idx_d = wr_idx_q + 3'd1;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end

      ST_CAPTURE: begin
        for (int k = 0; k < 8; k++) begin
          res_re_d[k] = fft_xr[32*k +: 32];
          res_im_d[k] = fft_xi[32*k +: 32];
        end
        rd_idx_d = 3'd0;
        state_d  = ST_UNLOAD;
      end

      ST_UNLOAD: begin
        if (out_ready) begin
          if (rd_idx_q == 3'd7) begin
            rd_idx_d      = 3'd0;
            frames_done_d = frames_done_q + 16'd1;
            state_d       = ST_LOAD;
          end else begin
            rd_idx_d = rd_idx_q + 3'd1;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // State, index, counter and bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the sample and result banks are reset too, not just control
      // state: fft_a and the result outputs must read zero out of reset.
      state_q       <= ST_LOAD;
      wr_idx_q      <= 3'd0;
      rd_idx_q      <= 3'd0;
      settle_cnt_q  <= 4'd0;
      frame_err_q   <= 1'b0;
      frames_done_q <= 16'd0;
      for (int k = 0; k < 8; k++) begin
        samp_q[k]   <= 32'd0;
        res_re_q[k] <= 32'd0;
        res_im_q[k] <= 32'd0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      settle_cnt_q  <= settle_cnt_d;
      frame_err_q   <= frame_err_d;
      frames_done_q <= frames_done_d;
      samp_q        <= samp_d;
      res_re_q      <= res_re_d;
      res_im_q      <= res_im_d;
    end
  end

  // Pack the sample lanes onto the core input bus.
  always_comb begin
    fft_a = '0;
    for (int k = 0; k < 8; k++) begin
      fft_a[32*k +: 32] = samp_q[k];
    end
  end

  // Handshake and result outputs are decoded from state only.
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = (state_q == ST_UNLOAD);
    out_idx   = rd_idx_q;
    out_last  = out_valid && (rd_idx_q == 3'd7);
    out_re    = out_valid ? res_re_q[rd_idx_q] : 32'd0;
    out_im    = out_valid ? res_im_q[rd_idx_q] : 32'd0;
  end

  assign frame_err   = frame_err_q;
  assign frames_done = frames_done_q;

endmodule

// File: doc/fft8_frame_ctrl.md
# fft8_frame_ctrl

Sequencing controller for the combinational 8-point FFT core (`fft8`). It accepts a serial stream of 32-bit sign-magnitude samples and assembles them into 8-sample frames. It holds each frame stable on the core inputs for a programmable settle window, then captures the 16 result words. It streams the results back out as 8 complex beats with valid/ready backpressure. It sits between the sample source and any downstream consumer, so that neither side has to drive the core's 256-bit parallel ports.

## Interface
- SETTLE_CYCLES, 2: cycles the core inputs are held stable before capture (multicycle path for the combinational core). Legal range is 1..15.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  controller can accept a sample.
- in_data  in  32  sample: bit 31 is the sign, [30:0] is the magnitude.
- in_last  in  1  marks the final sample of a frame; legal only on sample index 7.
- fft_a  out  256  core inputs; lane k (A_k) is bits [32k+31:32k].
- fft_xr  in  256  core real outputs; lane k (Xr_k) is bits [32k+31:32k].
- fft_xi  in  256  core imaginary outputs, same lane packing as fft_xr.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_re  out  32  Xr of the current bin.
- out_im  out  32  Xi of the current bin.
- out_idx  out  3  bin index of the current beat, 0..7.
- out_last  out  1  high on the bin 7 beat.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- frames_done  out  16  count of completed frames; wraps at 65535 -> 0.

## Operation
- The state machine has four states: LOAD, SETTLE, CAPTURE, UNLOAD.
- LOAD:
  - in_ready = 1.
  - On each handshake (in_valid & in_ready), in_data is written to sample register lane wr_idx, and wr_idx increments.
  - When the handshake occurs at wr_idx = 7, the controller moves to SETTLE, loads the settle counter with SETTLE_CYCLES-1, and clears wr_idx.
  - If in_last is set on a handshake with wr_idx < 7, the frame is aborted: frame_err pulses on the next cycle, wr_idx clears, the controller stays in LOAD, and the partial lanes are discarded.
  - At wr_idx = 7, in_last = 0 is accepted; in_last is only a check, not a requirement.
- fft_a always reflects the sample registers. Lanes change only in LOAD, so fft_a is stable throughout SETTLE, CAPTURE and UNLOAD.
- SETTLE: in_ready = 0. The settle counter decrements each cycle; on counter = 0 the controller moves to CAPTURE.
- CAPTURE: a one-cycle state. It registers all 8 lanes of fft_xr and fft_xi into the result bank, then moves to UNLOAD with rd_idx = 0.
- UNLOAD:
  - Outputs: out_valid = 1, out_re/out_im = result lane rd_idx, out_idx = rd_idx, out_last = (rd_idx == 7).
  - On each handshake (out_valid & out_ready), rd_idx increments.
  - On the handshake at rd_idx = 7, frames_done increments and the controller returns to LOAD.
- Data passes through the controller unmodified. It applies no arithmetic to samples or results; sign-magnitude encoding is the core's concern.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - state = LOAD, so in_ready = 1 immediately.
  - out_valid, out_last, frame_err = 0.
  - out_re, out_im, out_idx = 0.
  - fft_a = 0, frames_done = 0.
  - Result bank, wr_idx and rd_idx are cleared.
- Latency: if the 8th sample is accepted at cycle t:
  - SETTLE occupies t+1 .. t+SETTLE_CYCLES.
  - CAPTURE occurs at t+SETTLE_CYCLES+1.
  - out_valid rises at t+SETTLE_CYCLES+2.
- With continuous out_ready, the final beat transfers at t+SETTLE_CYCLES+9, and in_ready returns at t+SETTLE_CYCLES+10.
- Throughput is one frame per (8 + SETTLE_CYCLES + 1 + 8) cycles minimum. There is no overlap of load and unload.
- in_ready is a function of state only; it never depends on in_valid.
- Output stability: out_valid, out_re, out_im, out_idx and out_last hold constant while out_valid & !out_ready, including indefinite stalls.
- Input gaps: in_valid low in LOAD simply pauses filling. Partial lanes are kept.
- frame_err and a new sample in the same cycle: a handshake on the cycle after an abort is accepted as index 0 of the new frame.
- Reset mid-frame, in any state, drops all data. No beat or frames_done increment occurs for the interrupted frame.
- frames_done 65535 plus one completed frame gives 0. There is no saturation.

## Test plan
- Load the frame 120, 130, 0, 110, 0, 150, 200, 0 (in_last on the 8th) with `fft8` attached and out_ready = 1. Required: beat idx 0 has out_re = 710 (0x000002C6) and out_im = 0; beat idx 4 has out_re = 0x80000046 (-70); out_last is high only on idx 7; frames_done = 1; out_valid first rises exactly SETTLE_CYCLES+2 cycles after the 8th accept.
- In_last misaligned: assert in_last on the 3rd sample. Required: frame_err pulses once, there is no out_valid, and the next 8 samples form a correct frame with idx 0 = sum of those samples.
- Backpressure: hold out_ready low for 5 cycles at idx 2, then toggle it every other cycle. Required: all outputs stay stable while stalled, each bin appears exactly once in order 0..7, and in_ready stays 0 until after the idx 7 handshake.
- Input gaps and settle parameter: with SETTLE_CYCLES = 4, insert random in_valid gaps while loading. Required: fft_a lanes match the accepted order, and fft_a does not change from the 8th accept until in_ready returns.
- Reset mid-UNLOAD: pulse rst_n low at idx 3. Required: out_valid drops asynchronously, frames_done = 0, fft_a = 0, and in_ready = 1.
- Counter wrap: force or run 65536 frames. Required: frames_done reads 0 after the last one.
